// File: rtl/mixer_pkg.sv
// Shared encoding for the carrier/code mixers and accumulators: input
// magnitude levels, product width and the magnitude lookup.
package mixer_pkg;

    localparam int unsigned IF_MAG_LO   = 1;
    localparam int unsigned IF_MAG_HI   = 3;
    localparam int unsigned CARR_MAG_LO = 1;
    localparam int unsigned CARR_MAG_HI = 2;
    localparam int unsigned MIX_MAG_W   = 3;

    // Exact product of the decoded magnitudes; the largest case (3 x 2 = 6)
    // fits in MIX_MAG_W bits, so no rounding or saturation is needed.
    function automatic logic [MIX_MAG_W-1:0] mix_mag_f(input logic if_mag,
                                                       input logic carrier_mag);
        logic [MIX_MAG_W-1:0] if_lvl;
        logic [MIX_MAG_W-1:0] carr_lvl;
        if_lvl   = if_mag      ? MIX_MAG_W'(IF_MAG_HI)   : MIX_MAG_W'(IF_MAG_LO);
        carr_lvl = carrier_mag ? MIX_MAG_W'(CARR_MAG_HI) : MIX_MAG_W'(CARR_MAG_LO);
        return if_lvl * carr_lvl;
    endfunction

endpackage

// File: rtl/carrier_mixer_core.sv
// Combinational sign/magnitude multiplier: sign agreement via XNOR and the
// magnitude from the shared lookup.
module carrier_mixer_core
    import mixer_pkg::*;
(
    input  logic                 if_sign,
    input  logic                 if_mag,
    input  logic                 carrier_sign,
    input  logic                 carrier_mag,
    output logic                 mix_sign,
    output logic [MIX_MAG_W-1:0] mix_mag
);

    // Product is positive when both signs agree; magnitude comes from the table.
    always_comb begin
        mix_sign = ~(if_sign ^ carrier_sign);
        mix_mag  = mix_mag_f(if_mag, carrier_mag);
    end

endmodule

// File: rtl/carrier_mixer.sv
// Carrier wipe-off for one tracking channel: multiplies the 2-bit IF sample by
// the 2-bit local carrier, optionally registering the sign/magnitude product
// so the downstream accumulator sees a clock-aligned input.
module carrier_mixer
    import mixer_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 if_sign,
    input  logic                 if_mag,
    input  logic                 carrier_sign,
    input  logic                 carrier_mag,
    output logic                 mix_sign,
    output logic [MIX_MAG_W-1:0] mix_mag
);

    logic                 prod_sign;
    logic [MIX_MAG_W-1:0] prod_mag;

    carrier_mixer_core u_core (
        .if_sign      (if_sign),
        .if_mag       (if_mag),
        .carrier_sign (carrier_sign),
        .carrier_mag  (carrier_mag),
        .mix_sign     (prod_sign),
        .mix_mag      (prod_mag)
    );

    if (OUT_REG) begin : g_reg
        // Output register: reset wins over en, so a sample in flight is dropped;
        // mag 0 after reset means "no contribution".
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (rst) begin
                mix_sign <= 1'b0;
                mix_mag  <= '0;
            end else if (en) begin
                mix_sign <= prod_sign;
                mix_mag  <= prod_mag;
            end
        end
    end else begin : g_comb
        // clk, rst and en have no function in the combinational build.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst, en};

        // Pass the core product straight through; no reset value exists here.
        always_comb begin
            mix_sign = prod_sign;
            mix_mag  = prod_mag;
        end
    end

endmodule

// File: tb/tb_carrier_mixer.sv
// Bench for carrier_mixer: registered build driven by directed and random
// stimulus against an integer-arithmetic model, plus a combinational build
// swept over every input combination.
module tb_carrier_mixer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       if_sign = 1'b0, if_mag = 1'b0, carrier_sign = 1'b0, carrier_mag = 1'b0;
    logic       r_sign;
    logic [2:0] r_mag;

    logic       c_if_sign = 1'b0, c_if_mag = 1'b0, c_carrier_sign = 1'b0, c_carrier_mag = 1'b0;
    logic       c_sign;
    logic [2:0] c_mag;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_val  = 0;   // signed product currently expected on the registered outputs

    always #5 clk = ~clk;

    carrier_mixer #(.OUT_REG(1'b1)) u_dut_reg (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .if_sign      (if_sign),
        .if_mag       (if_mag),
        .carrier_sign (carrier_sign),
        .carrier_mag  (carrier_mag),
        .mix_sign     (r_sign),
        .mix_mag      (r_mag)
    );

    carrier_mixer #(.OUT_REG(1'b0)) u_dut_comb (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .if_sign      (c_if_sign),
        .if_mag       (c_if_mag),
        .carrier_sign (c_carrier_sign),
        .carrier_mag  (c_carrier_mag),
        .mix_sign     (c_sign),
        .mix_mag      (c_mag)
    );

    // Reference: decode both samples to integers and multiply.
    function automatic int model_prod(input logic s1, m1, s2, m2);
        int iv, cv;
        iv = (s1 ? 1 : -1) * (m1 ? 3 : 1);
        cv = (s2 ? 1 : -1) * (m2 ? 2 : 1);
        return iv * cv;
    endfunction

    function automatic int exp_sign_of(input int v);
        return (v > 0) ? 1 : 0;
    endfunction

    function automatic int exp_mag_of(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // One clock of the registered build: drive on the falling edge, update the
    // model at the rising edge, sample 1 ns later.
    task automatic step(input string tag, input logic r, e, s1, m1, s2, m2);
        @(negedge clk);
        rst = r; en = e;
        if_sign = s1; if_mag = m1; carrier_sign = s2; carrier_mag = m2;
        @(posedge clk);
        if (r)      exp_val = 0;
        else if (e) exp_val = model_prod(s1, m1, s2, m2);
        #1;
        check({tag, ".sign"}, int'(r_sign), exp_sign_of(exp_val));
        check({tag, ".mag"},  int'(r_mag),  exp_mag_of(exp_val));
    endtask

    initial begin
        logic [3:0] v;

        // Reset state
        step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Exhaustive sweep, en=1
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            step($sformatf("sweep%0d", i), 1'b0, 1'b1, v[3], v[2], v[1], v[0]);
        end

        // Reset held 2 cycles with +3/+2 and en=1, then first product +6
        step("rst_hold0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("rst_hold1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("rst_rel",   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Enable hold: +6 loaded, en dropped with -1 x +1 on the inputs
        step("hold_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("hold_resume", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Mid-stream reset while alternating +6 and -3
        for (int i = 0; i < 8; i++) begin
            if (i[0]) step($sformatf("alt%0d", i), i == 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            else      step($sformatf("alt%0d", i), 1'b0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        end

        // Random traffic with occasional reset and random enable
        for (int i = 0; i < 200; i++) begin
            v = 4'($urandom);
            step($sformatf("rand%0d", i), ($urandom_range(0, 15) == 0), 1'($urandom),
                 v[3], v[2], v[1], v[0]);
        end

        // Combinational build: every combination, checked 1 ns after the change
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            c_if_sign = v[3]; c_if_mag = v[2]; c_carrier_sign = v[1]; c_carrier_mag = v[0];
            #1;
            check($sformatf("comb%0d.sign", i), int'(c_sign), exp_sign_of(model_prod(v[3], v[2], v[1], v[0])));
            check($sformatf("comb%0d.mag", i),  int'(c_mag),  exp_mag_of(model_prod(v[3], v[2], v[1], v[0])));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
